// File: rtl/hazard_unit.sv
// hazard_unit: E/M/W scoreboard driving operand forwarding, load-use stalls, PC-write/branch flushes and event counters
module hazard_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSD,
  input  logic             BranchTakenE,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [REG_W-1:0] PC_REG = REG_W'(15);
  logic [REG_W-1:0] r_ra1e, r_ra2e, r_wa3e, r_wa3m, r_wa3w;
  logic             r_regwrite_e, r_memtoreg_e, r_pcs_e;
  logic             r_regwrite_m, r_pcs_m, r_regwrite_w, r_pcs_w;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_ldr_stall, w_pc_wr_pend;
  // Forwarding selects prefer the younger M result; R15 reads always come from the register file
  always_comb begin
    ForwardAE    = (r_ra1e == PC_REG) ? 2'b00 :
                   (r_regwrite_m && r_ra1e == r_wa3m) ? 2'b10 :
                   (r_regwrite_w && r_ra1e == r_wa3w) ? 2'b01 : 2'b00;
    ForwardBE    = (r_ra2e == PC_REG) ? 2'b00 :
                   (r_regwrite_m && r_ra2e == r_wa3m) ? 2'b10 :
                   (r_regwrite_w && r_ra2e == r_wa3w) ? 2'b01 : 2'b00;
    w_ldr_stall  = r_memtoreg_e & r_regwrite_e & ((RA1D == r_wa3e) | (RA2D == r_wa3e));
    w_pc_wr_pend = PCSD | r_pcs_e | r_pcs_m;
    StallD       = w_ldr_stall & ~BranchTakenE;
    StallF       = (w_ldr_stall | w_pc_wr_pend) & ~BranchTakenE;
    FlushD       = w_pc_wr_pend | r_pcs_w | BranchTakenE;
    FlushE       = w_ldr_stall | BranchTakenE;
  end
  // Advance the scoreboard; a flushed E slot keeps its addresses but loses its side-effect flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_ra1e, r_ra2e, r_wa3e, r_wa3m, r_wa3w} <= '0;
      {r_regwrite_e, r_memtoreg_e, r_pcs_e} <= '0;
      {r_regwrite_m, r_pcs_m, r_regwrite_w, r_pcs_w} <= '0;
    end else begin
      r_ra1e       <= RA1D;
      r_ra2e       <= RA2D;
      r_wa3e       <= WA3D;
      r_regwrite_e <= RegWriteD & ~FlushE;
      r_memtoreg_e <= MemtoRegD & ~FlushE;
      r_pcs_e      <= PCSD & ~FlushE;
      r_wa3m       <= r_wa3e;
      r_regwrite_m <= r_regwrite_e;
      r_pcs_m      <= r_pcs_e;
      r_wa3w       <= r_wa3m;
      r_regwrite_w <= r_regwrite_m;
      r_pcs_w      <= r_pcs_m;
    end
  end
  // Saturating event counters; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= cnt_clr ? '0 : (StallD && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
      r_flush_cnt <= cnt_clr ? '0 : (FlushE && r_flush_cnt != '1) ? r_flush_cnt + 1'b1 : r_flush_cnt;
    end
  end
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of forwarding, load-use, PC-write, branch override, counters and reset
module tb_hazard_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] RA1D = '0, RA2D = '0, WA3D = '0;
  logic       RegWriteD = 1'b0, MemtoRegD = 1'b0, PCSD = 1'b0, BranchTakenE = 1'b0, cnt_clr = 1'b0;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [3:0] stall_count, flush_count;
  int         checks = 0;
  int         errors = 0;
  int         n;

  hazard_unit #(.REG_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSD(PCSD), .BranchTakenE(BranchTakenE),
    .cnt_clr(cnt_clr), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                      input logic rw, input logic mr, input logic pcs, input logic bt);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mr; PCSD = pcs; BranchTakenE = bt;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic sf, input logic sd, input logic fd, input logic fe);
    chk({tag, "_StallF"}, 32'(StallF), 32'(sf));
    chk({tag, "_StallD"}, 32'(StallD), 32'(sd));
    chk({tag, "_FlushD"}, 32'(FlushD), 32'(fd));
    chk({tag, "_FlushE"}, 32'(FlushE), 32'(fe));
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk_ctl("rst", 0, 0, 0, 0);
    chk("rst_fwdA", 32'(ForwardAE), 0);
    chk("rst_fwdB", 32'(ForwardBE), 0);
    chk("rst_scnt", 32'(stall_count), 0);
    chk("rst_fcnt", 32'(flush_count), 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk_ctl("idle", 0, 0, 0, 0);
    chk("idle_fwdA", 32'(ForwardAE), 0);
    chk("idle_scnt", 32'(stall_count), 0);

    setd(0, 0, 1, 1, 0, 0, 0);
    tick();
    setd(1, 0, 0, 0, 0, 0, 0);
    tick();
    #1 chk("alu_fwdA_M", 32'(ForwardAE), 2);
    setd(1, 0, 0, 0, 0, 0, 0);
    tick();
    #1 chk("alu_fwdA_W", 32'(ForwardAE), 1);
    setd(0, 0, 15, 1, 0, 0, 0);
    tick();
    setd(15, 15, 0, 0, 0, 0, 0);
    tick();
    #1 chk("pc_fwdA", 32'(ForwardAE), 0);
    chk("pc_fwdB", 32'(ForwardBE), 0);
    setd(0, 0, 3, 1, 0, 0, 0);
    tick();
    setd(0, 0, 3, 1, 0, 0, 0);
    tick();
    setd(0, 3, 0, 0, 0, 0, 0);
    tick();
    #1 chk("prio_fwdB", 32'(ForwardBE), 2);
    setd(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("alu_scnt", 32'(stall_count), 0);

    setd(0, 0, 2, 1, 1, 0, 0);
    tick();
    setd(0, 2, 5, 0, 0, 0, 0);
    chk_ctl("ldu_stall", 1, 1, 0, 1);
    tick();
    #1 chk_ctl("ldu_bubble", 0, 0, 0, 0);
    tick();
    #1 chk("ldu_fwdB", 32'(ForwardBE), 1);
    chk("ldu_scnt", 32'(stall_count), 1);
    chk("ldu_fcnt", 32'(flush_count), 1);
    setd(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    setd(0, 0, 0, 0, 0, 1, 0);
    chk_ctl("pcw_D", 1, 0, 1, 0);
    tick();
    setd(0, 0, 0, 0, 0, 0, 0);
    chk_ctl("pcw_E", 1, 0, 1, 0);
    tick();
    #1 chk_ctl("pcw_M", 1, 0, 1, 0);
    tick();
    #1 chk_ctl("pcw_W", 0, 0, 1, 0);
    tick();
    #1 chk_ctl("pcw_done", 0, 0, 0, 0);

    setd(0, 0, 2, 1, 1, 0, 0);
    tick();
    setd(2, 0, 0, 0, 0, 0, 1);
    chk_ctl("br_ldu", 0, 0, 1, 1);
    tick();
    setd(0, 0, 0, 0, 0, 0, 0);
    chk("br_fcnt", 32'(flush_count), 2);
    chk("br_scnt", 32'(stall_count), 1);
    repeat (3) tick();

    setd(2, 0, 2, 1, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 60 && n < 20; i++) begin
      if (StallD) n++;
      tick();
      #1;
    end
    chk("sat_nstalls", 32'(n), 20);
    chk("sat_scnt", 32'(stall_count), 15);
    chk("sat_fcnt", 32'(flush_count), 15);
    tick();
    #1 chk("clr_stallD", 32'(StallD), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1 chk("clr_scnt", 32'(stall_count), 0);
    chk("clr_fcnt", 32'(flush_count), 0);
    repeat (3) tick();
    #1 chk("pre_rst_stallD", 32'(StallD), 1);
    chk("pre_rst_scnt", 32'(stall_count), 1);
    reset = 1'b0;
    #1 chk("arst_scnt", 32'(stall_count), 0);
    chk("arst_fcnt", 32'(flush_count), 0);
    chk_ctl("arst", 0, 0, 0, 0);
    chk("arst_fwdA", 32'(ForwardAE), 0);
    setd(0, 0, 0, 0, 0, 0, 1);
    chk_ctl("arst_br", 0, 0, 1, 1);
    setd(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard and forwarding unit for the 5-stage pipelined ARM core.
- It is the producer of the stallD/flushD/flushE controls that pipelineControlUnit consumes.
- It keeps its own E/M/W scoreboard of destination registers and write/load/PC-write flags, pipelined from Decode.
- From that scoreboard it generates operand forwarding selects, load-use stalls, branch/PC-write flushes, and saturating stall/flush event counters.

Parameters:
REG_W, 4, register-address width (16 architectural registers; R15 = PC)
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
RA1D  in  REG_W  Decode source register 1 address
RA2D  in  REG_W  Decode source register 2 address
WA3D  in  REG_W  Decode destination register address
RegWriteD  in  1  Decode instruction writes the register file
MemtoRegD  in  1  Decode instruction is a load
PCSD  in  1  Decode instruction writes PC (R15 destination or branch)
BranchTakenE  in  1  branch resolved taken in Execute (from control unit)
cnt_clr  in  1  synchronous clear of both event counters
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUOutM
ForwardBE  out  2  SrcB select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register (insert bubble)
stall_count  out  CNT_W  cycles with StallD=1
flush_count  out  CNT_W  cycles with FlushE=1

Behaviour:
- Scoreboard registers, all cleared to 0 on reset low, asynchronously:
  - E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSE
  - M stage: WA3M, RegWriteM, PCSM
  - W stage: WA3W, RegWriteW, PCSW
- Each rising clk:
  - E <= D values, unless FlushE=1. On FlushE, RegWriteE, MemtoRegE and PCSE load 0; the address fields still load.
  - M <= E and W <= M, unconditionally.
- Forwarding (combinational, from scoreboard only):
  - ForwardAE = 10 if RegWriteM and RA1E==WA3M.
  - Else ForwardAE = 01 if RegWriteW and RA1E==WA3W.
  - Else ForwardAE = 00.
  - Whenever RA1E==15, ForwardAE = 00 (PC never forwarded).
  - ForwardBE is identical, using RA2E.
  - M has priority over W on a double match.
- Hazard terms:
  - LDRstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E)
  - PCWrPend = PCSD | PCSE | PCSM
- Outputs:
  - StallD = LDRstall & ~BranchTakenE
  - StallF = (LDRstall | PCWrPend) & ~BranchTakenE
  - FlushD = PCWrPend | PCSW | BranchTakenE
  - FlushE = LDRstall | BranchTakenE
- A taken branch overrides stalls. Both fetch and decode are discarded, so holding them is meaningless.
- Load-use latency: exactly one bubble. The cycle after LDRstall, E holds the bubble and the load is in M. Forwarding then selects 01 from W the following cycle.
- PC write latency: from PCSD=1, StallF stays high while the instruction is in D, E and M. FlushD stays high in D, E, M and W, i.e. 4 cycles of FlushD for an isolated PC write with no other hazards.
- Counters, reset to 0:
  - stall_count increments on clk when StallD=1; flush_count increments when FlushE=1.
  - Both saturate at all-ones and do not wrap.
  - cnt_clr=1 forces both to 0 that cycle and takes priority over increment.
- Reset behaviour:
  - Asserting reset mid-operation clears the scoreboard and counters immediately.
  - With reset held and RegWriteD/MemtoRegD/PCSD/BranchTakenE all 0, every output is 0.
  - Outputs are combinational on D-stage inputs and BranchTakenE, so those inputs still reach StallF/FlushD/FlushE during reset.

Test Plan:
- Reset: hold reset=0 with all inputs 0 -> all outputs 0, both counters 0; release, idle 5 cycles -> unchanged.
- ALU back-to-back: ADD R1 (WA3D=1, RegWriteD=1), then next cycle an instruction with RA1D=1:
  - when it reaches E -> ForwardAE=10;
  - a second consumer one cycle later -> ForwardAE=01;
  - RA1=15 case -> ForwardAE=00.
- Load-use: LDR R2 (MemtoRegD=1, RegWriteD=1, WA3D=2) followed by RA2D=2:
  - exactly 1 cycle of StallF=StallD=FlushE=1;
  - then ForwardBE=01;
  - stall_count=1, flush_count=1.
- PC write: isolated PCSD=1 -> StallF high 3 consecutive cycles, FlushD high 4 consecutive cycles, then all 0.
- Taken branch during load-use: LDRstall and BranchTakenE=1 same cycle -> StallF=StallD=0, FlushD=FlushE=1, flush_count +1, stall_count unchanged.
- Counters: CNT_W=4, force 20 stall cycles -> stall_count saturates at 15; cnt_clr=1 with StallD=1 -> 0 next cycle; async reset mid-stall -> scoreboard and counters 0 without a clock edge.
